// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer_if
//  Brief    : Switch/button/LED bundle between the board and the shift sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if;
    logic [15:0] sw;
    logic [3:0]  btn;
    logic [15:0] led;

    modport master (output sw, output btn, input led);
    modport slave  (input sw, input btn, output led);
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Brief    : Latches an 8-bit operand and animates up to 7 one-bit shift/rotate
//             steps on the LEDs, one step per TICK_DIV clock cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int TICK_DIV = 25_000_000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shift_sequencer_if.slave bus
);

    // Bit 0 of the encoding is busy and bit 1 is done, so the LEDs come straight off flops.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int                  c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);

    logic [3:0]          r_btn_s1;
    logic [3:0]          r_btn_s2;
    logic [3:0]          r_btn_prev;
    logic [3:0]          w_pulse;
    logic                w_load;
    logic                w_start;
    logic                w_abort;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_data;
    logic [7:0]          w_data_nxt;
    logic [7:0]          w_data_step;
    logic [2:0]          r_rem;
    logic [2:0]          w_rem_nxt;
    logic [1:0]          r_op;
    logic [1:0]          w_op_nxt;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_TICK_W-1:0] w_tick_nxt;

    logic                w_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s1   <= 4'h0;
            r_btn_s2   <= 4'h0;
            r_btn_prev <= 4'h0;
        end else begin
            r_btn_s1   <= bus.btn;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
        end
    end

    assign w_pulse = r_btn_s2 & ~r_btn_prev;
    assign w_load  = w_pulse[0];
    assign w_start = w_pulse[1];
    assign w_abort = w_pulse[3];

    always_comb begin
        w_data_step = r_data;
        case (r_op)
            2'b00:   w_data_step = {r_data[6:0], 1'b0};
            2'b01:   w_data_step = {1'b0, r_data[7:1]};
            2'b10:   w_data_step = {r_data[6:0], r_data[7]};
            default: w_data_step = {r_data[0], r_data[7:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= 8'h00;
            r_rem   <= 3'd0;
            r_op    <= 2'b00;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_tick_nxt  = r_tick;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = 3'd0;
            w_tick_nxt  = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt = '0;
                        w_data_nxt = w_data_step;
                        w_rem_nxt  = r_rem - 3'd1;
                        if (r_rem == 3'd1) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_ONE;
                    end
                end
                default: begin
                    // Load wins over a simultaneous start; the start is simply dropped.
                    if (w_load) begin
                        w_data_nxt  = bus.sw[7:0];
                        w_rem_nxt   = 3'd0;
                        w_state_nxt = ST_IDLE;
                    end else if (w_start) begin
                        w_op_nxt    = bus.sw[12:11];
                        w_rem_nxt   = bus.sw[10:8];
                        w_tick_nxt  = '0;
                        w_state_nxt = (bus.sw[10:8] == 3'd0) ? ST_DONE : ST_RUN;
                    end
                end
            endcase
        end
    end

    assign bus.led = {1'b0, r_state[1], r_state[0], r_op, r_rem, r_data};

    assign w_unused = &{1'b0, bus.sw[15:13], w_pulse[2]};

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_sequencer
//  Brief    : Directed + randomized self-checking bench for shift_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int c_TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_check = 0;

    // Reference model: 0 idle, 1 run, 2 done
    int         m_st;
    logic [1:0] m_op;
    logic [2:0] m_rem;
    logic [7:0] m_data;

    shift_sequencer_if bus ();

    shift_sequencer #(.TICK_DIV(c_TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] after_steps(input logic [7:0] d0, input logic [1:0] op, input int k);
        int d;
        int x;
        d = int'(d0);
        case (op)
            2'b00:   x = d << k;
            2'b01:   x = d >> k;
            2'b10:   x = (d << k) | (d >> (8 - k));
            default: x = (d >> k) | (d << (8 - k));
        endcase
        return 8'(x & 255);
    endfunction

    function automatic logic [15:0] exp_led();
        return {1'b0, (m_st == 2), (m_st == 1), m_op, m_rem, m_data};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_check++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Button held for three edges: the action lands on the third one.
    task automatic press(input logic [3:0] mask);
        bus.btn = mask;
        step(3);
        bus.btn = 4'h0;
    endtask

    task automatic do_load(input logic [15:0] s);
        bus.sw = s;
        press(4'b0001);
        m_data = s[7:0];
        m_rem  = 3'd0;
        m_st   = 0;
        chk("load", bus.led, exp_led());
        step(2);
    endtask

    task automatic do_abort();
        press(4'b1000);
        m_st  = 0;
        m_rem = 3'd0;
        chk("abort", bus.led, exp_led());
        step(2);
    endtask

    // stop_at > 0 aborts right after that step; noise presses load+start during the run.
    task automatic run_op(input logic [1:0] op, input logic [2:0] n, input int stop_at, input bit noise);
        logic [7:0] d0;
        bus.sw = {3'($urandom), op, n, 8'($urandom)};
        press(4'b0010);
        d0     = m_data;
        m_op   = op;
        m_rem  = n;
        m_st   = (n == 3'd0) ? 2 : 1;
        bus.sw = 16'($urandom);
        chk("entry", bus.led, exp_led());
        for (int k = 1; k <= int'(n); k++) begin
            if (noise && k == 1) bus.btn = 4'b0011;
            step(c_TICK_DIV - 1);
            bus.btn = 4'h0;
            chk("hold", bus.led, exp_led());
            step(1);
            m_data = after_steps(d0, op, k);
            m_rem  = 3'(int'(n) - k);
            if (k == int'(n)) m_st = 2;
            chk("step", bus.led, exp_led());
            if (k == stop_at) begin
                do_abort();
                return;
            end
        end
        step(2);
        chk("settle", bus.led, exp_led());
    endtask

    initial begin
        rst     = 1'b1;
        bus.sw  = 16'h0000;
        bus.btn = 4'h0;
        m_st = 0; m_op = 2'b00; m_rem = 3'd0; m_data = 8'h00;
        step(2);
        chk("reset", bus.led, 16'h0000);
        rst = 1'b0;
        step(2);
        chk("post_reset", bus.led, 16'h0000);

        // Worked example: rol 3 on 0x96
        do_load(16'h0896);
        chk("t1_load", bus.led, 16'h0096);
        run_op(2'b10, 3'd3, 0, 1'b0);
        chk("t1_final", bus.led, 16'h50B4);

        // Zero fill and wrap boundaries
        do_load(16'h0080);
        run_op(2'b01, 3'd7, 0, 1'b0);
        chk("shr7", {8'h00, bus.led[7:0]}, 16'h0001);
        do_load(16'h00FF);
        run_op(2'b00, 3'd7, 0, 1'b0);
        chk("shl7", {8'h00, bus.led[7:0]}, 16'h0080);
        do_load(16'h0001);
        run_op(2'b11, 3'd1, 0, 1'b0);
        chk("ror1", {8'h00, bus.led[7:0]}, 16'h0080);
        do_load(16'h0080);
        run_op(2'b10, 3'd1, 0, 1'b0);
        chk("rol1", {8'h00, bus.led[7:0]}, 16'h0001);

        // Restart from DONE reuses data; zero-step start goes straight to DONE
        run_op(2'b10, 3'd2, 0, 1'b0);
        run_op(2'b01, 3'd0, 0, 1'b0);
        do_abort();

        // Abort after the second step
        do_load(16'h0096);
        run_op(2'b10, 3'd5, 2, 1'b0);
        chk("abort_val", bus.led, 16'h105A);
        step(c_TICK_DIV * 2);
        chk("abort_hold", bus.led, exp_led());

        // Load and start together: load only
        bus.sw = 16'h0B3C;
        press(4'b0011);
        m_data = 8'h3C; m_rem = 3'd0; m_st = 0;
        chk("load_start", bus.led, exp_led());
        step(c_TICK_DIV * 3);
        chk("load_start_idle", bus.led, exp_led());

        // Held start gives exactly one run
        do_load(16'h0096);
        bus.sw  = {3'b000, 2'b01, 3'd2, 8'h00};
        bus.btn = 4'b0010;
        step(100);
        m_op = 2'b01; m_rem = 3'd0; m_st = 2; m_data = 8'h25;
        chk("held_start", bus.led, exp_led());
        bus.btn = 4'h0;
        step(4);
        chk("held_release", bus.led, exp_led());

        // Load/start pressed during RUN are ignored
        do_load(16'h00C3);
        run_op(2'b11, 3'd4, 0, 1'b1);

        // Asynchronous reset mid-run
        do_load(16'h005A);
        bus.sw = {3'b000, 2'b00, 3'd6, 8'h00};
        press(4'b0010);
        step(5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", bus.led, 16'h0000);
        #1;
        rst = 1'b0;
        m_st = 0; m_op = 2'b00; m_rem = 3'd0; m_data = 8'h00;
        step(3);
        chk("after_rst", bus.led, exp_led());

        // Randomized runs against the model
        for (int i = 0; i < 8; i++) begin
            do_load(16'($urandom));
            run_op(2'($urandom), 3'($urandom_range(0, 7)), 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
